// File: rtl/point_sequencer.sv
// Game-flow controller: walks each point through menu, serve countdown, rally, scoring and game over.
// Latency: start/POINT -> ball_reset 1 cycle, last tick -> serve 1 cycle, wall hit -> score 1 cycle.
// No backpressure: inputs are sampled every cycle; pulses are single-cycle and never stalled.
module point_sequencer #(
    parameter int WIN_SCORE         = 5,
    parameter int SERVE_DELAY_TICKS = 60,
    parameter int X_MIN             = 10,
    parameter int X_MAX             = 1013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        start,
    input  logic        restart,
    input  logic [10:0] x_ball,
    output logic        still_graphic,
    output logic        ball_reset,
    output logic        serve,
    output logic        serve_dir,
    output logic [3:0]  player1_score,
    output logic [3:0]  player2_score,
    output logic        game_over
);

    localparam int CW = $clog2(SERVE_DELAY_TICKS + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(SERVE_DELAY_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [10:0]   XMIN     = 11'(X_MIN);
    localparam logic [10:0]   XMAX     = 11'(X_MAX);
    localparam logic [4:0]    WIN      = 5'(WIN_SCORE);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SERVE_WAIT = 3'd1;
    localparam logic [2:0] ST_RALLY      = 3'd2;
    localparam logic [2:0] ST_POINT      = 3'd3;
    localparam logic [2:0] ST_GAME_OVER  = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_p1;
    logic [3:0]    r_p2;
    logic          r_ball_reset;
    logic          r_serve;
    logic          r_serve_dir;

    logic [3:0]    w_p1_inc;
    logic [3:0]    w_p2_inc;
    logic          w_win;

    // Saturating score increments and end-of-game detection
    always_comb begin
        w_p1_inc = (r_p1 == 4'hF) ? r_p1 : r_p1 + 4'd1;
        w_p2_inc = (r_p2 == 4'hF) ? r_p2 : r_p2 + 4'd1;
        w_win    = ({1'b0, r_p1} >= WIN) || ({1'b0, r_p2} >= WIN);
    end

    // Game FSM, countdown, scores and one-cycle control pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_p1         <= 4'd0;
            r_p2         <= 4'd0;
            r_ball_reset <= 1'b0;
            r_serve      <= 1'b0;
            r_serve_dir  <= 1'b0;
        end else begin
            r_ball_reset <= 1'b0;
            r_serve      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_p1         <= 4'd0;
                        r_p2         <= 4'd0;
                        r_serve_dir  <= 1'b0;
                        r_cnt        <= CNT_LOAD;
                        r_ball_reset <= 1'b1;
                        r_state      <= ST_SERVE_WAIT;
                    end
                end
                ST_SERVE_WAIT: begin
                    if (timing_tick) begin
                        r_cnt <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_serve <= 1'b1;
                            r_state <= ST_RALLY;
                        end
                    end
                end
                ST_RALLY: begin
                    // Left wall wins a tie so a bad X_MIN/X_MAX pair cannot score both sides
                    if (x_ball <= XMIN) begin
                        r_p2        <= w_p2_inc;
                        r_serve_dir <= 1'b0;
                        r_state     <= ST_POINT;
                    end else if (x_ball >= XMAX) begin
                        r_p1        <= w_p1_inc;
                        r_serve_dir <= 1'b1;
                        r_state     <= ST_POINT;
                    end
                end
                ST_POINT: begin
                    // Re-centring here moves the ball out of the goal zone before the next rally
                    if (w_win) begin
                        r_state <= ST_GAME_OVER;
                    end else begin
                        r_cnt        <= CNT_LOAD;
                        r_ball_reset <= 1'b1;
                        r_state      <= ST_SERVE_WAIT;
                    end
                end
                ST_GAME_OVER: begin
                    // Scores stay visible in the menu until the next start
                    if (restart) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Freeze and game-over flags decode straight from the state register
    always_comb begin
        still_graphic = (r_state != ST_RALLY);
        game_over     = (r_state == ST_GAME_OVER);
    end

    assign ball_reset    = r_ball_reset;
    assign serve         = r_serve;
    assign serve_dir     = r_serve_dir;
    assign player1_score = r_p1;
    assign player2_score = r_p2;

endmodule

// File: tb/tb_point_sequencer.sv
// Bench for point_sequencer: table of directed vectors plus async-reset corner sequences.
// Latency: outputs are checked 1 time unit after each rising clock edge.
// No backpressure: every vector is applied for a fixed number of cycles.
module tb_point_sequencer;

    logic        clk;
    logic        rst;
    logic        timing_tick;
    logic        start;
    logic        restart;
    logic [10:0] x_ball;
    logic        still_graphic;
    logic        ball_reset;
    logic        serve;
    logic        serve_dir;
    logic [3:0]  player1_score;
    logic [3:0]  player2_score;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic        tick;
        logic        st;
        logic        rs;
        logic [10:0] x;
        int          reps;
        logic [12:0] exp;   // {still, ball_reset, serve, serve_dir, p1[3:0], p2[3:0], game_over}
    } vec_t;

    vec_t vecs[$];

    point_sequencer #(
        .WIN_SCORE        (5),
        .SERVE_DELAY_TICKS(3),
        .X_MIN            (10),
        .X_MAX            (1013)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .timing_tick  (timing_tick),
        .start        (start),
        .restart      (restart),
        .x_ball       (x_ball),
        .still_graphic(still_graphic),
        .ball_reset   (ball_reset),
        .serve        (serve),
        .serve_dir    (serve_dir),
        .player1_score(player1_score),
        .player2_score(player2_score),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r_n, input logic tk, input logic s, input logic r,
                       input int x, input int reps,
                       input logic e_still, input logic e_br, input logic e_srv, input logic e_dir,
                       input int e_p1, input int e_p2, input logic e_go);
        vec_t v;
        v.rst_n = r_n;
        v.tick  = tk;
        v.st    = s;
        v.rs    = r;
        v.x     = 11'(x);
        v.reps  = reps;
        v.exp   = {e_still, e_br, e_srv, e_dir, 4'(e_p1), 4'(e_p2), e_go};
        vecs.push_back(v);
    endtask

    function automatic logic [12:0] outs();
        return {still_graphic, ball_reset, serve, serve_dir, player1_score, player2_score, game_over};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got still=%b br=%b srv=%b dir=%b p1=%0d p2=%0d go=%b, want still=%b br=%b srv=%b dir=%b p1=%0d p2=%0d go=%b",
                     name, act[12], act[11], act[10], act[9], act[8:5], act[4:1], act[0],
                     exp[12], exp[11], exp[10], exp[9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    initial begin
        rst         = 1'b0;
        timing_tick = 1'b0;
        start       = 1'b0;
        restart     = 1'b0;
        x_ball      = 11'd500;

        // Reset, start, and a first serve with ticks spaced 10 cycles apart
        add(0,0,0,0,500,2,  1,0,0,0, 0,0,0);
        add(1,0,1,0,500,1,  1,1,0,0, 0,0,0);
        add(1,0,0,0,500,1,  1,0,0,0, 0,0,0);
        for (int t = 0; t < 3; t++) begin
            add(1,1,0,0,500,1, (t == 2) ? 1'b0 : 1'b1, 0, (t == 2) ? 1'b1 : 1'b0, 0, 0,0,0);
            if (t < 2) add(1,0,0,0,500,9, 1,0,0,0, 0,0,0);
        end
        // start held during rally has no effect
        add(1,0,1,0,500,3,  0,0,0,0, 0,0,0);
        // Right wall: player 1 scores once, serve goes to player 2's side
        add(1,0,0,0,1013,1, 1,0,0,1, 1,0,0);
        add(1,0,0,0,1013,1, 1,1,0,1, 1,0,0);
        // Ball still at the wall and restart high during countdown: nothing happens
        add(1,0,0,1,1013,5, 1,0,0,1, 1,0,0);
        add(1,1,0,0,1013,2, 1,0,0,1, 1,0,0);
        add(1,1,0,0,500,1,  0,0,1,1, 1,0,0);
        // Five left-wall exits: player 2 reaches the winning score
        for (int k = 1; k <= 5; k++) begin
            add(1,0,0,0,5,1, 1,0,0,0, 1,k,0);
            if (k < 5) begin
                add(1,0,0,0,5,1, 1,1,0,0, 1,k,0);
                add(1,1,0,0,5,2, 1,0,0,0, 1,k,0);
                add(1,1,0,0,5,1, 0,0,1,0, 1,k,0);
            end else begin
                add(1,0,0,0,5,1, 1,0,0,0, 1,5,1);
            end
        end
        // start ignored in game over; restart returns to menu with scores kept
        add(1,0,1,0,5,2,    1,0,0,0, 1,5,1);
        add(1,0,0,1,500,1,  1,0,0,0, 1,5,0);
        add(1,0,0,0,500,2,  1,0,0,0, 1,5,0);
        // New game clears scores
        add(1,0,1,0,500,1,  1,1,0,0, 0,0,0);
        add(1,1,0,0,500,2,  1,0,0,0, 0,0,0);
        add(1,1,0,0,500,1,  0,0,1,0, 0,0,0);
        // Build a 3/2 score and leave the game in rally
        for (int j = 0; j < 5; j++) begin
            add(1,0,0,0,(j < 3) ? 1013 : 5,1, 1,0,0,(j < 3) ? 1'b1 : 1'b0,
                (j < 3) ? j + 1 : 3, (j < 3) ? 0 : j - 2, 0);
            add(1,0,0,0,500,1, 1,1,0,(j < 3) ? 1'b1 : 1'b0, (j < 3) ? j + 1 : 3, (j < 3) ? 0 : j - 2, 0);
            add(1,1,0,0,500,2, 1,0,0,(j < 3) ? 1'b1 : 1'b0, (j < 3) ? j + 1 : 3, (j < 3) ? 0 : j - 2, 0);
            add(1,1,0,0,500,1, 0,0,1,(j < 3) ? 1'b1 : 1'b0, (j < 3) ? j + 1 : 3, (j < 3) ? 0 : j - 2, 0);
        end
        add(1,0,0,0,500,2,  0,0,0,0, 3,2,0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                rst         = vecs[i].rst_n;
                timing_tick = vecs[i].tick;
                start       = vecs[i].st;
                restart     = vecs[i].rs;
                x_ball      = vecs[i].x;
                @(posedge clk);
                #1;
                check($sformatf("vec%0d.%0d", i, r), outs(), vecs[i].exp);
            end
        end

        // Asynchronous reset mid-rally with scores 3/2: no clock edge needed
        timing_tick = 1'b0;
        start       = 1'b0;
        restart     = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_rally", outs(), {1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0});
        @(posedge clk);
        #1;
        check("rst_held", outs(), {1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0});
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_rst", outs(), {1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0});

        // Reset drops a ball_reset pulse that is in flight
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_pulse", outs(), {1'b1,1'b1,1'b0,1'b0,4'd0,4'd0,1'b0});
        start = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("pulse_dropped", outs(), {1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0});
        rst = 1'b1;
        // Back in IDLE: ticks alone must never produce a serve
        timing_tick = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("idle_no_serve", outs(), {1'b1,1'b0,1'b0,1'b0,4'd0,4'd0,1'b0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
